// File: rtl/p1_disp_pkg.sv
// Shared constants for the P1 display scanner: digit count, blank pattern,
// active-high hex segment table and the digit-to-anode one-hot table.
package p1_disp_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_t;

    // Segment patterns are {g,f,e,d,c,b,a}; bit set means segment lit.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Packed table indexed by nibble; entry 0 sits in the least significant slot.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    localparam logic [NUM_DIGITS-1:0][3:0] DIGIT_AN = {
        4'b1000, 4'b0100, 4'b0010, 4'b0001
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble-to-segment decoder, active-high {g..a} output.
module hex7seg
    import p1_disp_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[value];

endmodule

// File: rtl/p1_display_scanner.sv
// Synchronises and debounces the MCU51 P1 port, counts accepted changes and
// scans both values onto a 4-digit multiplexed 7-segment display.
module p1_display_scanner
    import p1_disp_pkg::*;
#(
    parameter int SCAN_DIV       = 25000,
    parameter int STABLE_CYCLES  = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] p1_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic [7:0] p1_value,
    output logic [7:0] change_cnt,
    output logic       change_pulse
);

    localparam int              STAB_W   = $clog2(STABLE_CYCLES + 1);
    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_POL  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]      AN_POL   = SEG_ACTIVE_LOW ? 4'hF  : 4'h0;
    localparam logic            DP_POL   = SEG_ACTIVE_LOW;

    generate
        if (STABLE_CYCLES < 1 || SCAN_DIV < 2) begin : g_param_check
            $error("p1_display_scanner: need STABLE_CYCLES>=1 and SCAN_DIV>=2");
        end
    endgenerate

    logic [7:0]        sync1, sync2, candidate;
    logic [STAB_W-1:0] stab_cnt;
    logic [DIV_W-1:0]  div_cnt;
    digit_t            digit;
    logic [3:0]        digit_src;
    logic [6:0]        seg_hi;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would collapse sync1/sync2 into one flop.
    always_ff @(posedge CLK) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            candidate    <= '0;
            stab_cnt     <= '0;
            p1_value     <= '0;
            change_cnt   <= '0;
            change_pulse <= 1'b0;
        end else begin
            sync1        <= p1_in;
            sync2        <= sync1;
            change_pulse <= 1'b0;
            // Any movement restarts the window, so A->B->A never gets accepted.
            if (sync2 != candidate) begin
                candidate <= sync2;
                stab_cnt  <= '0;
            end else if (stab_cnt < STAB_MAX) begin
                stab_cnt <= stab_cnt + STAB_W'(1);
            end else if (candidate != p1_value) begin
                p1_value     <= candidate;
                change_cnt   <= change_cnt + 8'd1;
                change_pulse <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            div_cnt <= '0;
            digit   <= '0;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt <= '0;
            digit   <= (digit == digit_t'(NUM_DIGITS - 1)) ? digit_t'(0) : digit + digit_t'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // NOTE: give always_comb outputs a default first so no path leaves them
    // unassigned, which would infer a latch.
    always_comb begin
        digit_src = p1_value[3:0];
        case (digit)
            2'd1:    digit_src = p1_value[7:4];
            2'd2:    digit_src = change_cnt[3:0];
            2'd3:    digit_src = change_cnt[7:4];
            default: digit_src = p1_value[3:0];
        endcase
    end

    hex7seg u_hex7seg (
        .value (digit_src),
        .seg   (seg_hi)
    );

    // Polarity is folded in with an XOR mask; blank is "nothing lit" in either polarity.
    always_ff @(posedge CLK) begin
        if (reset) begin
            an  <= AN_POL;
            seg <= SEG_BLANK ^ SEG_POL;
            dp  <= DP_POL;
        end else begin
            an  <= DIGIT_AN[digit] ^ AN_POL;
            seg <= seg_hi ^ SEG_POL;
            dp  <= (digit == digit_t'(2)) ^ DP_POL;
        end
    end

endmodule

// File: tb/tb_p1_display_scanner.sv
// Directed self-checking bench for p1_display_scanner (SCAN_DIV=4, STABLE_CYCLES=16, active-low).
module tb_p1_display_scanner;

    logic       CLK = 1'b0;
    logic       reset;
    logic [7:0] p1_in;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [7:0] p1_value;
    logic [7:0] change_cnt;
    logic       change_pulse;

    int total = 0;
    int bad   = 0;

    p1_display_scanner #(
        .SCAN_DIV       (4),
        .STABLE_CYCLES  (16),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .p1_in        (p1_in),
        .seg          (seg),
        .dp           (dp),
        .an           (an),
        .p1_value     (p1_value),
        .change_cnt   (change_cnt),
        .change_pulse (change_pulse)
    );

    always #5 CLK = ~CLK;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Active-low segment patterns {g..a}, written out by hand.
    function automatic logic [6:0] lo_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (change_pulse) cnt++;
        end
    endtask

    task automatic wait_pulse(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            tick();
            if (change_pulse) seen = 1'b1;
        end
    endtask

    task automatic do_reset(input logic [7:0] val);
        reset = 1'b1;
        p1_in = val;
        tick();
        tick();
        reset = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        p1_in = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({an, seg, dp, p1_value, change_pulse} !== {4'hF, 7'h7F, 1'b1, 8'h00, 1'b0}) begin
                bad++;
                $display("FAIL reset_hold cyc%0d: an=%b seg=%h dp=%b p1=%h pulse=%b, want an=1111 seg=7f dp=1 p1=00 pulse=0",
                         i, an, seg, dp, p1_value, change_pulse);
            end
        end
        reset = 1'b0;
        // Edge 1 after release is the first to sample A5; acceptance lands on edge 19.
        tick();
        total++;
        if (an !== 4'b1110 || seg !== lo_seg(4'h0)) begin
            bad++;
            $display("FAIL first_digit: an=%b seg=%b, want an=1110 seg=%b", an, seg, lo_seg(4'h0));
        end
        repeat (17) tick();
        total++;
        if (p1_value !== 8'h00 || change_pulse !== 1'b0) begin
            bad++;
            $display("FAIL accept_early: p1=%h pulse=%b, want p1=00 pulse=0", p1_value, change_pulse);
        end
        tick();
        total++;
        if (p1_value !== 8'hA5 || change_pulse !== 1'b1 || change_cnt !== 8'd1) begin
            bad++;
            $display("FAIL accept: p1=%h pulse=%b cnt=%0d, want p1=a5 pulse=1 cnt=1", p1_value, change_pulse, change_cnt);
        end
        tick();
        total++;
        if (change_pulse !== 1'b0 || change_cnt !== 8'd1) begin
            bad++;
            $display("FAIL pulse_width: pulse=%b cnt=%0d, want pulse=0 cnt=1", change_pulse, change_cnt);
        end
    endtask

    task automatic test_glitch();
        int pulses;
        do_reset(8'h00);
        p1_in = 8'hFF;
        repeat (10) tick();
        p1_in = 8'h00;
        count_pulses(40, pulses);
        total++;
        if (pulses !== 0 || p1_value !== 8'h00 || change_cnt !== 8'd0) begin
            bad++;
            $display("FAIL glitch: pulses=%0d p1=%h cnt=%0d, want pulses=0 p1=00 cnt=0", pulses, p1_value, change_cnt);
        end
    endtask

    task automatic test_aba();
        int pulses;
        bit seen;
        p1_in = 8'h3C;
        wait_pulse(40, seen);
        total++;
        if (!seen || p1_value !== 8'h3C || change_cnt !== 8'd1) begin
            bad++;
            $display("FAIL aba_setup: seen=%b p1=%h cnt=%0d, want seen=1 p1=3c cnt=1", seen, p1_value, change_cnt);
        end
        p1_in = 8'hC3;
        repeat (8) tick();
        p1_in = 8'h3C;
        count_pulses(40, pulses);
        total++;
        if (pulses !== 0 || p1_value !== 8'h3C || change_cnt !== 8'd1) begin
            bad++;
            $display("FAIL aba_return: pulses=%0d p1=%h cnt=%0d, want pulses=0 p1=3c cnt=1", pulses, p1_value, change_cnt);
        end
        p1_in = 8'hC3;
        count_pulses(40, pulses);
        total++;
        if (pulses !== 1 || p1_value !== 8'hC3 || change_cnt !== 8'd2) begin
            bad++;
            $display("FAIL aba_hold: pulses=%0d p1=%h cnt=%0d, want pulses=1 p1=c3 cnt=2", pulses, p1_value, change_cnt);
        end
    endtask

    task automatic test_restart();
        int pulses;
        p1_in = 8'h11;
        repeat (10) tick();
        p1_in = 8'h22;
        // The window restarts on 22, so acceptance is 19 ticks after the switch.
        count_pulses(18, pulses);
        total++;
        if (pulses !== 0 || p1_value !== 8'hC3) begin
            bad++;
            $display("FAIL restart_early: pulses=%0d p1=%h, want pulses=0 p1=c3", pulses, p1_value);
        end
        tick();
        total++;
        if (change_pulse !== 1'b1 || p1_value !== 8'h22 || change_cnt !== 8'd3) begin
            bad++;
            $display("FAIL restart_accept: pulse=%b p1=%h cnt=%0d, want pulse=1 p1=22 cnt=3", change_pulse, p1_value, change_cnt);
        end
        count_pulses(30, pulses);
        total++;
        if (pulses !== 0 || change_cnt !== 8'd3) begin
            bad++;
            $display("FAIL restart_quiet: pulses=%0d cnt=%0d, want pulses=0 cnt=3", pulses, change_cnt);
        end
    endtask

    task automatic test_scan();
        bit seen;
        bit found;
        logic [3:0] prev_an;
        logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] exp_seg [4];
        logic       exp_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        exp_seg[0] = lo_seg(4'h5);
        exp_seg[1] = lo_seg(4'hA);
        exp_seg[2] = lo_seg(4'h4);
        exp_seg[3] = lo_seg(4'h0);
        p1_in = 8'hA5;
        wait_pulse(40, seen);
        total++;
        if (!seen || p1_value !== 8'hA5 || change_cnt !== 8'd4) begin
            bad++;
            $display("FAIL scan_setup: seen=%b p1=%h cnt=%0d, want seen=1 p1=a5 cnt=4", seen, p1_value, change_cnt);
        end
        found   = 1'b0;
        prev_an = an;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
            prev_an = an;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL scan_align: digit 0 start not seen, an=%b want 1110", an);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (an !== exp_an[i/4] || seg !== exp_seg[i/4] || dp !== exp_dp[i/4]) begin
                bad++;
                $display("FAIL scan_cyc%0d: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                         i, an, seg, dp, exp_an[i/4], exp_seg[i/4], exp_dp[i/4]);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        int  accepted;
        bit  seen;
        bit  found;
        do_reset(8'h00);
        accepted = 0;
        for (int k = 0; k < 256; k++) begin
            p1_in = (k % 2 == 0) ? 8'h55 : 8'h00;
            wait_pulse(40, seen);
            if (seen) accepted++;
        end
        total++;
        if (accepted !== 256 || change_cnt !== 8'h00 || p1_value !== 8'h00) begin
            bad++;
            $display("FAIL wrap: accepted=%0d cnt=%h p1=%h, want accepted=256 cnt=00 p1=00", accepted, change_cnt, p1_value);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (an == 4'b1011) found = 1'b1;
        end
        total++;
        if (!found || seg !== lo_seg(4'h0) || dp !== 1'b0) begin
            bad++;
            $display("FAIL wrap_d2: found=%b seg=%b dp=%b, want found=1 seg=%b dp=0", found, seg, dp, lo_seg(4'h0));
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (an == 4'b0111) found = 1'b1;
        end
        total++;
        if (!found || seg !== lo_seg(4'h0) || dp !== 1'b1) begin
            bad++;
            $display("FAIL wrap_d3: found=%b seg=%b dp=%b, want found=1 seg=%b dp=1", found, seg, dp, lo_seg(4'h0));
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        reset = 1'b1;
        p1_in = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        // 77 is first sampled on edge 13, becomes candidate on edge 15, so it is
        // 10 cycles into its window after edge 25 while digit is 2.
        repeat (12) tick();
        p1_in = 8'h77;
        repeat (13) tick();
        total++;
        if (an !== 4'b1011 || p1_value !== 8'h00) begin
            bad++;
            $display("FAIL mid_pre: an=%b p1=%h, want an=1011 p1=00", an, p1_value);
        end
        reset = 1'b1;
        p1_in = 8'h00;
        tick();
        total++;
        if ({an, seg, dp, p1_value, change_cnt, change_pulse} !== {4'hF, 7'h7F, 1'b1, 8'h00, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset: an=%b seg=%h dp=%b p1=%h cnt=%h pulse=%b, want 1111 7f 1 00 00 0",
                     an, seg, dp, p1_value, change_cnt, change_pulse);
        end
        reset = 1'b0;
        tick();
        total++;
        if (an !== 4'b1110) begin
            bad++;
            $display("FAIL mid_restart: an=%b, want 1110", an);
        end
        count_pulses(30, pulses);
        total++;
        if (pulses !== 0 || p1_value !== 8'h00 || change_cnt !== 8'h00) begin
            bad++;
            $display("FAIL mid_pending: pulses=%0d p1=%h cnt=%h, want pulses=0 p1=00 cnt=00", pulses, p1_value, change_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        p1_in = 8'h00;
        test_reset();
        test_glitch();
        test_aba();
        test_restart();
        test_scan();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
